mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the write-back stage. Holds the byte-addressed data memory and performs word, halfword and byte loads and stores, including sign/zero extension. Registers its results into the MEM/WB latch that drives the write-back inputs (`reg_write`, `mem_to_reg`, `mem_data`, `alu_result`, `selected_reg`). Also provides a registered debug read port for the debug unit's memory dump.

## Interface
- `NB_DATA`, 32, data/word width
- `NB_REG`, 5, register-index width
- `NB_ADDR`, 7, word-address width (memory = 2^NB_ADDR words)
- `i_clock`  in  1  single clock; all state updates on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_MEM_enable`  in  1  pipeline advance; 0 = hold latch and suppress stores
- `i_MEM_flush`  in  1  insert bubble into MEM/WB latch
- `i_MEM_mem_read`  in  1  load instruction
- `i_MEM_mem_write`  in  1  store instruction
- `i_MEM_word_size`  in  2  00 byte, 01 halfword, 11 word (10 treated as word)
- `i_MEM_unsigned`  in  1  1 = zero-extend loads, 0 = sign-extend
- `i_MEM_alu_result`  in  NB_DATA  byte address / pass-through result
- `i_MEM_write_data`  in  NB_DATA  store data (rt)
- `i_MEM_selected_reg`  in  NB_REG  destination register
- `i_MEM_reg_write`, `i_MEM_mem_to_reg`  in  1 each  WB controls, passed through
- `i_MEM_debug_addr`  in  NB_ADDR  debug word address
- `o_WB_reg_write`, `o_WB_mem_to_reg`  out  1 each  latched controls
- `o_WB_mem_data`  out  NB_DATA  extended load data
- `o_WB_alu_result`  out  NB_DATA  latched ALU result
- `o_WB_selected_reg`  out  NB_REG  latched destination
- `o_MEM_debug_data`  out  NB_DATA  word at debug address, registered

## Operation
- Word index = `alu_result[NB_ADDR+1:2]`. Upper bits are ignored, so addresses wrap modulo 2^NB_ADDR words.
- Store (`mem_write & enable & ~flush & ~reset`) writes on the clock edge using byte enables:
  - byte: lane `addr[1:0]` gets `write_data[7:0]`
  - half: lanes selected by `addr[1]` get `write_data[15:0]`; `addr[0]` is ignored
  - word: all lanes; `addr[1:0]` ignored
- Little-endian lanes: byte 0 = bits [7:0].
- Load: the addressed word is read combinationally and the lane is selected with the same rules as stores.
  - Result is extended to NB_DATA: replicate the MSB when `unsigned=0`, zeros when `unsigned=1`.
  - Word loads are unextended.
- `o_WB_mem_data` latches the extended value whenever the latch advances, even with `mem_read=0`. Write-back selection uses `mem_to_reg`.
- `mem_read` and `mem_write` both set: the store is performed, and `mem_data` captures the pre-store contents.
- Flush: latch loads `reg_write=0`, `mem_to_reg=0`, `selected_reg=0`, data 0. The store is suppressed. Flush overrides `enable=0`.
- Hold (`enable=0`, no flush): all latch outputs keep their value; no store.
- Memory contents are not cleared by reset. Simulation initial value is 0.
- Debug port: `o_MEM_debug_data` ← `mem[debug_addr]` every cycle, independent of enable/flush. A same-cycle store to that word returns the old value (read-before-write).

## Timing
- Reset: all outputs (`o_WB_*`, `o_MEM_debug_data`) become 0 at the first edge with `i_reset=1`. A store presented during reset is dropped.
- Latency: inputs sampled at edge N appear on `o_WB_*` after edge N (one cycle).
- A store at edge N is visible to a load sampled at edge N+1, and on the debug port after edge N+1.
- Back-to-back store then load to the same word needs no stall.

## Test plan
- **Reset mid-operation:** with a store of 0xDEADBEEF pending, assert reset 1 cycle → all outputs 0; debug read of that word returns the prior value.
- **Word and byte access:**
  - SW 0x8899AABB @0x10, then LW @0x10 → `o_WB_mem_data`=0x8899AABB one cycle after the load.
  - LB @0x13 signed → 0xFFFFFF88; LBU @0x13 → 0x00000088.
- **Halfword access:** SH 0x1234 @0x22 onto word 0xFFFFFFFF → word 0x1234FFFF. LH @0x22 → 0x00001234; LH @0x20 → 0xFFFFFFFF; LHU @0x20 → 0x0000FFFF.
- **Wrap-around:** SW 0x5 @ (4·2^NB_ADDR + 8) → debug read word 2 = 0x5.
- **Hold and flush:**
  - enable=0 with SW 0x1 @0x0 → word unchanged, outputs held.
  - flush with `reg_write=1`, `selected_reg=7` → `o_WB_reg_write`=0, `selected_reg`=0, no store.
- **Simultaneous read/write:** `mem_read=mem_write=1`, SW 0xA @0x4 over 0xB → `mem_data`=0xB, next-cycle LW=0xA. A same-cycle debug read of word 1 returns 0xB.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the five-stage MIPS pipeline. It sits between the
// EX/MEM register and write-back. It holds the byte-addressed data memory and
// performs word, halfword and byte loads and stores, with sign or zero
// extension on loads. Its results are registered into the MEM/WB latch. A
// separate registered debug port lets the debug unit dump memory one word at
// a time.
//
// Ports
//   i_clock / i_reset        clock; synchronous active-high reset
//   i_MEM_enable             pipeline advance (0 = hold latch, no store)
//   i_MEM_flush              load a bubble into MEM/WB (overrides enable)
//   i_MEM_mem_read           load instruction (load path is always active)
//   i_MEM_mem_write          store instruction
//   i_MEM_word_size          00 byte, 01 half, 1x word
//   i_MEM_unsigned           1 = zero-extend loads, 0 = sign-extend
//   i_MEM_alu_result         byte address / pass-through result
//   i_MEM_write_data         store data (rt)
//   i_MEM_selected_reg       destination register
//   i_MEM_reg_write          WB control, passed through
//   i_MEM_mem_to_reg         WB control, passed through
//   i_MEM_debug_addr         debug word address
//   o_WB_*                   MEM/WB latch outputs
//   o_MEM_debug_data         mem[debug_addr], registered every cycle
//
// The lane logic assumes 32-bit words (four byte lanes, word index taken
// from alu_result[NB_ADDR+1:2]).
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_MEM_enable,
  input  logic               i_MEM_flush,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic [1:0]         i_MEM_word_size,
  input  logic               i_MEM_unsigned,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_write_data,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic [NB_ADDR-1:0] i_MEM_debug_addr,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic [NB_DATA-1:0] o_WB_mem_data,
  output logic [NB_DATA-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic [NB_DATA-1:0] o_MEM_debug_data
);

  localparam int NB_LANES = NB_DATA / 8;
  localparam int N_WORDS  = 2 ** NB_ADDR;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD_ALT = 2'b10,
    SIZE_WORD     = 2'b11
  } size_e;

  logic [NB_DATA-1:0]  mem [N_WORDS];

  logic [NB_ADDR-1:0]  word_idx;
  logic [1:0]          byte_off;
  logic [NB_DATA-1:0]  rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [NB_LANES-1:0] byte_en;
  logic [NB_DATA-1:0]  wr_lanes;
  logic [NB_DATA-1:0]  load_ext;
  logic                store_en;

  // The load path reads every cycle so mem_data is latched even without a
  // load; mem_read therefore has no effect on the datapath.
  logic unused_mem_read;
  assign unused_mem_read = i_MEM_mem_read;

  // Upper address bits are dropped, so addresses wrap modulo the memory size.
  assign word_idx = i_MEM_alu_result[NB_ADDR+1:2];
  assign byte_off = i_MEM_alu_result[1:0];
  assign rd_word  = mem[word_idx];
  assign rd_byte  = rd_word[{byte_off, 3'b000} +: 8];
  assign rd_half  = rd_word[{byte_off[1], 4'b0000} +: 16];

  assign store_en = i_MEM_mem_write & i_MEM_enable & ~i_MEM_flush & ~i_reset;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    byte_en  = '1;
    wr_lanes = i_MEM_write_data;
    load_ext = rd_word;
    case (size_e'(i_MEM_word_size))
      SIZE_BYTE: begin
        byte_en  = NB_LANES'(1) << byte_off;
        wr_lanes = {NB_LANES{i_MEM_write_data[7:0]}};
        load_ext = {{(NB_DATA-8){~i_MEM_unsigned & rd_byte[7]}}, rd_byte};
      end
      SIZE_HALF: begin
        byte_en  = NB_LANES'(2'b11) << {byte_off[1], 1'b0};
        wr_lanes = {(NB_DATA/16){i_MEM_write_data[15:0]}};
        load_ext = {{(NB_DATA-16){~i_MEM_unsigned & rd_half[15]}}, rd_half};
      end
      default: ;  // word: all lanes, unextended
    endcase
  end

  // NOTE: the data memory has no reset; its contents survive i_reset and it
  // maps onto plain RAM without a clear path.
  always_ff @(posedge i_clock) begin
    if (store_en) begin
      for (int i = 0; i < NB_LANES; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so the debug read
  // and the load below see memory as it was before this edge's store
  // (read-before-write falls out naturally).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_WB_reg_write    <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_mem_data     <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
      o_MEM_debug_data  <= '0;
    end else begin
      o_MEM_debug_data <= mem[i_MEM_debug_addr];
      if (i_MEM_flush) begin
        o_WB_reg_write    <= 1'b0;
        o_WB_mem_to_reg   <= 1'b0;
        o_WB_mem_data     <= '0;
        o_WB_alu_result   <= '0;
        o_WB_selected_reg <= '0;
      end else if (i_MEM_enable) begin
        o_WB_reg_write    <= i_MEM_reg_write;
        o_WB_mem_to_reg   <= i_MEM_mem_to_reg;
        o_WB_mem_data     <= load_ext;
        o_WB_alu_result   <= i_MEM_alu_result;
        o_WB_selected_reg <= i_MEM_selected_reg;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed bench for mem_stage. Stimulus tasks drive one pipeline slot per
// cycle and push the hand-computed response, stamped with the cycle it is
// due, into a scoreboard queue. A monitor on the falling edge pops and
// compares every entry that has come due.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_ADDR = 7;

  logic               i_clock = 1'b0;
  logic               i_reset;
  logic               i_MEM_enable;
  logic               i_MEM_flush;
  logic               i_MEM_mem_read;
  logic               i_MEM_mem_write;
  logic [1:0]         i_MEM_word_size;
  logic               i_MEM_unsigned;
  logic [NB_DATA-1:0] i_MEM_alu_result;
  logic [NB_DATA-1:0] i_MEM_write_data;
  logic [NB_REG-1:0]  i_MEM_selected_reg;
  logic               i_MEM_reg_write;
  logic               i_MEM_mem_to_reg;
  logic [NB_ADDR-1:0] i_MEM_debug_addr;
  logic               o_WB_reg_write;
  logic               o_WB_mem_to_reg;
  logic [NB_DATA-1:0] o_WB_mem_data;
  logic [NB_DATA-1:0] o_WB_alu_result;
  logic [NB_REG-1:0]  o_WB_selected_reg;
  logic [NB_DATA-1:0] o_MEM_debug_data;

  mem_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR)) dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_MEM_enable       (i_MEM_enable),
    .i_MEM_flush        (i_MEM_flush),
    .i_MEM_mem_read     (i_MEM_mem_read),
    .i_MEM_mem_write    (i_MEM_mem_write),
    .i_MEM_word_size    (i_MEM_word_size),
    .i_MEM_unsigned     (i_MEM_unsigned),
    .i_MEM_alu_result   (i_MEM_alu_result),
    .i_MEM_write_data   (i_MEM_write_data),
    .i_MEM_selected_reg (i_MEM_selected_reg),
    .i_MEM_reg_write    (i_MEM_reg_write),
    .i_MEM_mem_to_reg   (i_MEM_mem_to_reg),
    .i_MEM_debug_addr   (i_MEM_debug_addr),
    .o_WB_reg_write     (o_WB_reg_write),
    .o_WB_mem_to_reg    (o_WB_mem_to_reg),
    .o_WB_mem_data      (o_WB_mem_data),
    .o_WB_alu_result    (o_WB_alu_result),
    .o_WB_selected_reg  (o_WB_selected_reg),
    .o_MEM_debug_data   (o_MEM_debug_data)
  );

  always #5 i_clock = ~i_clock;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  typedef struct {
    string              name;
    int                 due;
    bit                 is_dbg;
    bit                 chk_md;
    logic               rw;
    logic               m2r;
    logic [NB_DATA-1:0] md;
    logic [NB_DATA-1:0] alu;
    logic [NB_REG-1:0]  sel;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   stim_done = 1'b0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [NB_DATA-1:0] act,
                       input logic [NB_DATA-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every scoreboard entry whose due cycle has arrived.
  always @(negedge i_clock) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.is_dbg) begin
        check({e.name, ".dbg"}, o_MEM_debug_data, e.md);
      end else begin
        check({e.name, ".reg_write"}, 32'(o_WB_reg_write), 32'(e.rw));
        check({e.name, ".mem_to_reg"}, 32'(o_WB_mem_to_reg), 32'(e.m2r));
        check({e.name, ".alu_result"}, o_WB_alu_result, e.alu);
        check({e.name, ".sel_reg"}, 32'(o_WB_selected_reg), 32'(e.sel));
        if (e.chk_md) check({e.name, ".mem_data"}, o_WB_mem_data, e.md);
      end
    end
  end

  // Inputs are driven #1 after the rising edge; results of this slot are
  // captured at the next edge and checked on the falling edge after it.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic rst, input logic en, input logic fl,
                       input logic mr, input logic mw, input logic [1:0] ws,
                       input logic uns, input logic [NB_DATA-1:0] addr,
                       input logic [NB_DATA-1:0] wd, input logic [NB_REG-1:0] sel,
                       input logic rw, input logic m2r, input logic [NB_ADDR-1:0] dbg);
    i_reset            = rst;
    i_MEM_enable       = en;
    i_MEM_flush        = fl;
    i_MEM_mem_read     = mr;
    i_MEM_mem_write    = mw;
    i_MEM_word_size    = ws;
    i_MEM_unsigned     = uns;
    i_MEM_alu_result   = addr;
    i_MEM_write_data   = wd;
    i_MEM_selected_reg = sel;
    i_MEM_reg_write    = rw;
    i_MEM_mem_to_reg   = m2r;
    i_MEM_debug_addr   = dbg;
  endtask

  task automatic exp_wb(input string name, input logic rw, input logic m2r,
                        input bit chk_md, input logic [NB_DATA-1:0] md,
                        input logic [NB_DATA-1:0] alu, input logic [NB_REG-1:0] sel);
    exp_t e;
    e.name = name; e.due = cyc + 1; e.is_dbg = 1'b0; e.chk_md = chk_md;
    e.rw = rw; e.m2r = m2r; e.md = md; e.alu = alu; e.sel = sel;
    sb_q.push_back(e);
  endtask

  task automatic exp_dbg(input string name, input logic [NB_DATA-1:0] val);
    exp_t e;
    e.name = name; e.due = cyc + 1; e.is_dbg = 1'b1; e.chk_md = 1'b1;
    e.rw = 1'b0; e.m2r = 1'b0; e.md = val; e.alu = '0; e.sel = '0;
    sb_q.push_back(e);
  endtask

  // Store: WB controls low; pre-store mem_data is not checked.
  task automatic store(input string name, input logic [1:0] ws,
                       input logic [NB_DATA-1:0] addr, input logic [NB_DATA-1:0] wd);
    drive(0, 1, 0, 0, 1, ws, 0, addr, wd, 5'd0, 0, 0, '0);
    exp_wb(name, 0, 0, 0, '0, addr, 5'd0);
    tick();
  endtask

  // Load into register 'sel' with reg_write and mem_to_reg set.
  task automatic load(input string name, input logic [1:0] ws, input logic uns,
                      input logic [NB_DATA-1:0] addr, input logic [NB_REG-1:0] sel,
                      input logic [NB_DATA-1:0] md);
    drive(0, 1, 0, 1, 0, ws, uns, addr, 32'h0, sel, 1, 1, '0);
    exp_wb(name, 1, 1, 1, md, addr, sel);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: all outputs 0.
    drive(1, 1, 0, 0, 0, SZ_W, 0, 32'h0, 32'h0, 5'd0, 0, 0, '0);
    exp_wb("reset", 0, 0, 1, 32'h0, 32'h0, 5'd0);
    exp_dbg("reset", 32'h0);
    tick();

    // Word and byte access.
    store("sw_10", SZ_W, 32'h10, 32'h8899AABB);
    load("lw_10", SZ_W, 0, 32'h10, 5'd8, 32'h8899AABB);
    load("lb_13", SZ_B, 0, 32'h13, 5'd9, 32'hFFFFFF88);
    load("lbu_13", SZ_B, 1, 32'h13, 5'd10, 32'h00000088);
    load("lb_10", SZ_B, 0, 32'h10, 5'd11, 32'hFFFFFFBB);
    load("lbu_11", SZ_B, 1, 32'h11, 5'd12, 32'h000000AA);
    load("lb_12", SZ_B, 0, 32'h12, 5'd13, 32'hFFFFFF99);

    // Halfword access; upper store-data bits must not leak.
    store("sw_20", SZ_W, 32'h20, 32'hFFFFFFFF);
    store("sh_22", SZ_H, 32'h22, 32'hABCD1234);
    load("lw_20", SZ_W, 0, 32'h20, 5'd1, 32'h1234FFFF);
    load("lh_22", SZ_H, 0, 32'h22, 5'd2, 32'h00001234);
    load("lh_20", SZ_H, 0, 32'h20, 5'd3, 32'hFFFFFFFF);
    load("lhu_20", SZ_H, 1, 32'h20, 5'd4, 32'h0000FFFF);
    store("sb_21", SZ_B, 32'h21, 32'hCCCCCC55);
    store("sh_25", SZ_H, 32'h25, 32'h00007788);   // addr[0] ignored: lanes 0,1
    load("lw_20b", SZ_W, 0, 32'h20, 5'd5, 32'h123455FF);
    load("lhu_23", SZ_H, 1, 32'h23, 5'd6, 32'h00001234);  // addr[0] ignored
    load("lh_24", SZ_H, 0, 32'h24, 5'd7, 32'h00007788);

    // Wrap-around: byte address 4*2^NB_ADDR + 8 lands on word 2.
    store("sw_wrap", SZ_W, 32'(4 * (2 ** NB_ADDR) + 8), 32'h5);
    drive(0, 1, 0, 0, 0, SZ_W, 0, 32'h0, 32'h0, 5'd0, 0, 0, 7'd2);
    exp_dbg("wrap", 32'h5);
    tick();

    // Hold: enable=0 keeps the latch and suppresses the store.
    store("sw_0", SZ_W, 32'h0, 32'h77);
    load("lw_0", SZ_W, 0, 32'h0, 5'd3, 32'h77);
    drive(0, 0, 0, 1, 1, SZ_W, 0, 32'h0, 32'h1, 5'd9, 0, 0, 7'd0);
    exp_wb("hold1", 1, 1, 1, 32'h77, 32'h0, 5'd3);
    tick();
    drive(0, 0, 0, 0, 0, SZ_B, 0, 32'h40, 32'h0, 5'd15, 0, 1, 7'd0);
    exp_wb("hold2", 1, 1, 1, 32'h77, 32'h0, 5'd3);
    exp_dbg("hold", 32'h77);
    tick();
    load("lw_0_hold", SZ_W, 0, 32'h0, 5'd4, 32'h77);

    // Flush overrides enable=0: bubble in the latch, store dropped.
    drive(0, 0, 1, 0, 1, SZ_W, 0, 32'h0, 32'h99, 5'd7, 1, 1, 7'd0);
    exp_wb("flush", 0, 0, 1, 32'h0, 32'h0, 5'd0);
    tick();
    load("lw_0_flush", SZ_W, 0, 32'h0, 5'd4, 32'h77);

    // Simultaneous read/write: mem_data and debug see the old word.
    store("sw_4", SZ_W, 32'h4, 32'hB);
    drive(0, 1, 0, 1, 1, SZ_W, 0, 32'h4, 32'hA, 5'd2, 1, 1, 7'd1);
    exp_wb("rmw", 1, 1, 1, 32'hB, 32'h4, 5'd2);
    exp_dbg("rmw", 32'hB);
    tick();
    drive(0, 1, 0, 1, 0, SZ_W, 0, 32'h4, 32'h0, 5'd2, 1, 1, 7'd1);
    exp_wb("lw_4", 1, 1, 1, 32'hA, 32'h4, 5'd2);
    exp_dbg("after_rmw", 32'hA);
    tick();

    // Reset mid-operation: pending store dropped, outputs cleared.
    store("sw_30", SZ_W, 32'h30, 32'h11111111);
    drive(1, 1, 0, 1, 1, SZ_W, 0, 32'h30, 32'hDEADBEEF, 5'd6, 1, 1, 7'd12);
    exp_wb("reset_mid", 0, 0, 1, 32'h0, 32'h0, 5'd0);
    exp_dbg("reset_mid", 32'h0);
    tick();
    drive(0, 1, 0, 1, 0, SZ_W, 0, 32'h30, 32'h0, 5'd6, 1, 1, 7'd12);
    exp_wb("lw_30", 1, 1, 1, 32'h11111111, 32'h30, 5'd6);
    exp_dbg("after_reset", 32'h11111111);
    tick();

    drive(0, 1, 0, 0, 0, SZ_W, 0, 32'h0, 32'h0, 5'd0, 0, 0, '0);
    tick();
    tick();

    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
